// File: rtl/sobel_pipe_if.sv
// Streaming interface for sobel_pipe.
//   in_valid/in_ready      : input handshake for comp_matrix + threshold
//   comp_matrix            : 3x3 unsigned window, index [row][col]
//   threshold              : unsigned edge threshold, travels with its pixel
//   out_valid/out_ready    : output handshake for out_mag + output_pixel
//   edge_cnt, cnt_clr      : saturating count of delivered edge pixels, sync clear
//   busy                   : any pipeline stage holds valid data
// modport slave is the block side; modport master is the driver/consumer side.
interface sobel_pipe_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [2:0][2:0][PIX_W-1:0] comp_matrix;
  logic [PIX_W+2:0]           threshold;
  logic                       out_valid;
  logic                       out_ready;
  logic                       output_pixel;
  logic [PIX_W+2:0]           out_mag;
  logic [CNT_W-1:0]           edge_cnt;
  logic                       cnt_clr;
  logic                       busy;

  modport master (
    output in_valid, comp_matrix, threshold, out_ready, cnt_clr,
    input  in_ready, out_valid, output_pixel, out_mag, edge_cnt, busy
  );

  modport slave (
    input  in_valid, comp_matrix, threshold, out_ready, cnt_clr,
    output in_ready, out_valid, output_pixel, out_mag, edge_cnt, busy
  );
endinterface

// File: rtl/sobel_pipe.sv
// Three-stage Sobel edge detector with a global stall.
//   clk   : rising-edge clock
//   n_rst : synchronous active-low reset
//   bus   : sobel_pipe_if slave (input window/threshold handshake, result handshake,
//           edge counter with clear, busy)
// S1 registers Gx/Gy, S2 registers |Gx|+|Gy|, S3 registers the result and edge flag.
// The threshold sampled with a window rides along to S2 where the compare happens.
module sobel_pipe #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        n_rst,
  sobel_pipe_if.slave bus
);
  localparam int unsigned W = PIX_W + 3;

  // Zero-extend a pixel into the signed gradient width.
  function automatic logic signed [W-1:0] ext1(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Twice a pixel, zero-extended into the signed gradient width.
  function automatic logic signed [W-1:0] ext2(input logic [PIX_W-1:0] p);
    return $signed({2'b00, p, 1'b0});
  endfunction

  logic                w_advance;
  logic                w_accept;
  logic                w_xfer;
  logic signed [W-1:0] w_gx;
  logic signed [W-1:0] w_gy;
  logic [W-1:0]        w_abs_gx;
  logic [W-1:0]        w_abs_gy;
  logic [W-1:0]        w_mag;

  logic                r_s1_valid;
  logic signed [W-1:0] r_gx;
  logic signed [W-1:0] r_gy;
  logic [W-1:0]        r_s1_thr;
  logic                r_s2_valid;
  logic [W-1:0]        r_s2_mag;
  logic [W-1:0]        r_s2_thr;
  logic                r_out_valid;
  logic [W-1:0]        r_out_mag;
  logic                r_out_pixel;
  logic [CNT_W-1:0]    r_edge_cnt;

  // Whole pipe moves together; only a held result at the output can stall it.
  assign w_advance = !r_out_valid || bus.out_ready;
  assign w_accept  = bus.in_valid && w_advance;
  assign w_xfer    = r_out_valid && bus.out_ready;

  always_comb begin
    w_gx = (ext1(bus.comp_matrix[0][2]) + ext2(bus.comp_matrix[1][2]) +
            ext1(bus.comp_matrix[2][2])) -
           (ext1(bus.comp_matrix[0][0]) + ext2(bus.comp_matrix[1][0]) +
            ext1(bus.comp_matrix[2][0]));
    w_gy = (ext1(bus.comp_matrix[2][0]) + ext2(bus.comp_matrix[2][1]) +
            ext1(bus.comp_matrix[2][2])) -
           (ext1(bus.comp_matrix[0][0]) + ext2(bus.comp_matrix[0][1]) +
            ext1(bus.comp_matrix[0][2]));
  end

  // |G| never exceeds 4*(2^PIX_W-1), so the negation cannot overflow.
  assign w_abs_gx = r_gx[W-1] ? -r_gx : r_gx;
  assign w_abs_gy = r_gy[W-1] ? -r_gy : r_gy;
  assign w_mag    = w_abs_gx + w_abs_gy;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_s1_valid  <= 1'b0;
      r_gx        <= '0;
      r_gy        <= '0;
      r_s1_thr    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_mag    <= '0;
      r_s2_thr    <= '0;
      r_out_valid <= 1'b0;
      r_out_mag   <= '0;
      r_out_pixel <= 1'b0;
    end else if (w_advance) begin
      // No input accepted means a bubble enters S1.
      r_s1_valid  <= w_accept;
      r_gx        <= w_gx;
      r_gy        <= w_gy;
      r_s1_thr    <= bus.threshold;
      r_s2_valid  <= r_s1_valid;
      r_s2_mag    <= w_mag;
      r_s2_thr    <= r_s1_thr;
      r_out_valid <= r_s2_valid;
      r_out_mag   <= r_s2_mag;
      r_out_pixel <= r_s2_mag > r_s2_thr;
    end
  end

  // Clear has priority over a same-cycle edge transfer; count saturates.
  always_ff @(posedge clk) begin
    if (!n_rst || bus.cnt_clr) begin
      r_edge_cnt <= '0;
    end else if (w_xfer && r_out_pixel && (r_edge_cnt != '1)) begin
      r_edge_cnt <= r_edge_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready     = w_advance;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_mag      = r_out_mag;
  assign bus.output_pixel = r_out_pixel;
  assign bus.edge_cnt     = r_edge_cnt;
  assign bus.busy         = r_s1_valid || r_s2_valid || r_out_valid;
endmodule

// File: tb/tb_sobel_pipe.sv
// Self-checking bench for sobel_pipe: two instances (16-bit and 4-bit edge counters)
// share one stimulus; a queue-based reference model predicts each delivered result.
module tb_sobel_pipe;
  localparam int unsigned PW = 8;
  localparam int unsigned MW = PW + 3;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  sobel_pipe_if #(.PIX_W(PW), .CNT_W(16)) ifa ();
  sobel_pipe_if #(.PIX_W(PW), .CNT_W(4))  ifb ();

  logic                    in_valid_d;
  logic                    out_ready_d;
  logic                    cnt_clr_d;
  logic [2:0][2:0][PW-1:0] mat_d;
  logic [MW-1:0]           thr_d;

  assign ifa.in_valid    = in_valid_d;
  assign ifa.out_ready   = out_ready_d;
  assign ifa.cnt_clr     = cnt_clr_d;
  assign ifa.comp_matrix = mat_d;
  assign ifa.threshold   = thr_d;
  assign ifb.in_valid    = in_valid_d;
  assign ifb.out_ready   = out_ready_d;
  assign ifb.cnt_clr     = cnt_clr_d;
  assign ifb.comp_matrix = mat_d;
  assign ifb.threshold   = thr_d;

  sobel_pipe #(.PIX_W(PW), .CNT_W(16)) u_dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
  sobel_pipe #(.PIX_W(PW), .CNT_W(4))  u_dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb));

  typedef struct {
    int mag;
    bit px;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cnt_a, cnt_b, n_deliv, last_mag;
  bit            last_px, last_acc, stall_prev;
  logic          last_rdy;
  logic [MW-1:0] prev_mag;
  logic          prev_px;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t ref_model(input logic [2:0][2:0][PW-1:0] m, input logic [MW-1:0] t);
    int   p[3][3];
    int   gx, gy, mag, ti;
    exp_t e;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) p[r][c] = m[r][c];
    gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    ti  = t;
    e.mag = mag;
    e.px  = mag > ti;
    return e;
  endfunction

  task automatic rand_mat();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mat_d[r][c] = PW'($urandom_range(0, 255));
  endtask

  // One clock cycle with the inputs the caller has set; checks outputs and updates the model.
  task automatic cycle();
    exp_t e;
    bit   xfer, epx;
    #1;
    last_rdy = ifa.in_ready;
    chk("in_ready", ifa.in_ready, !ifa.out_valid || out_ready_d);
    if (stall_prev) begin
      chk("hold_valid", ifa.out_valid, 1);
      chk("hold_mag", ifa.out_mag, prev_mag);
      chk("hold_pixel", ifa.output_pixel, prev_px);
    end
    xfer = ifa.out_valid && out_ready_d;
    epx  = 1'b0;
    if (xfer) begin
      if (q.size() == 0) begin
        chk("spurious_valid", ifa.out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("out_mag", ifa.out_mag, e.mag);
        chk("output_pixel", ifa.output_pixel, e.px);
        last_mag = ifa.out_mag;
        last_px  = ifa.output_pixel;
        epx      = e.px;
        n_deliv++;
      end
    end
    last_acc = in_valid_d && ifa.in_ready;
    if (last_acc) q.push_back(ref_model(mat_d, thr_d));
    if (cnt_clr_d) begin
      cnt_a = 0;
      cnt_b = 0;
    end else if (xfer && epx) begin
      if (cnt_a < 65535) cnt_a++;
      if (cnt_b < 15) cnt_b++;
    end
    stall_prev = ifa.out_valid && !out_ready_d;
    prev_mag   = ifa.out_mag;
    prev_px    = ifa.output_pixel;
    @(posedge clk);
    #1;
    chk("edge_cnt_a", ifa.edge_cnt, cnt_a);
    chk("edge_cnt_b", ifb.edge_cnt, cnt_b);
    chk("busy", ifa.busy, q.size() != 0);
  endtask

  task automatic drain();
    in_valid_d  = 1'b0;
    out_ready_d = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic send_one(input logic [MW-1:0] t);
    thr_d       = t;
    in_valid_d  = 1'b1;
    out_ready_d = 1'b1;
    cycle();
    drain();
  endtask

  task automatic do_reset();
    n_rst      = 1'b0;
    in_valid_d = 1'b0;
    cnt_clr_d  = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    cnt_a      = 0;
    cnt_b      = 0;
    stall_prev = 1'b0;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_edge_cnt_a", ifa.edge_cnt, 0);
    chk("rst_edge_cnt_b", ifb.edge_cnt, 0);
    chk("rst_out_mag", ifa.out_mag, 0);
    chk("rst_pixel", ifa.output_pixel, 0);
    n_rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int sent, n0, c0;
    n_rst = 1'b0;
    in_valid_d = 1'b0;
    out_ready_d = 1'b1;
    cnt_clr_d = 1'b0;
    mat_d = '0;
    thr_d = '0;
    n_deliv = 0;
    stall_prev = 1'b0;
    @(posedge clk);
    do_reset();
    in_valid_d = 1'b0;
    cycle();
    chk("post_rst_ready", last_rdy, 1);

    // Uniform field: no gradient, counter untouched.
    c0 = cnt_a;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mat_d[r][c] = 8'd100;
    send_one(11'd127);
    chk("uni_mag", last_mag, 0);
    chk("uni_pixel", last_px, 0);
    chk("uni_cnt", ifa.edge_cnt, c0);

    // Single-tap gradients around the strict threshold.
    mat_d = '0;
    mat_d[1][2] = 8'd64;
    send_one(11'd127);
    chk("gx_pos_mag", last_mag, 128);
    chk("gx_pos_pix127", last_px, 1);
    send_one(11'd128);
    chk("gx_pos_pix128", last_px, 0);
    mat_d = '0;
    mat_d[1][0] = 8'd64;
    send_one(11'd127);
    chk("gx_neg_mag", last_mag, 128);
    chk("gx_neg_pix", last_px, 1);

    // Full-scale corner and exact latency.
    mat_d = '0;
    for (int i = 0; i < 3; i++) begin
      mat_d[i][2] = 8'd255;
      mat_d[2][i] = 8'd255;
    end
    thr_d = 11'd127;
    in_valid_d = 1'b1;
    out_ready_d = 1'b1;
    cycle();
    chk("lat_accept", last_acc, 1);
    in_valid_d = 1'b0;
    chk("lat_c1", ifa.out_valid, 0);
    cycle();
    chk("lat_c2", ifa.out_valid, 0);
    cycle();
    chk("lat_c3", ifa.out_valid, 1);
    cycle();
    chk("max_mag", last_mag, 1530);
    chk("max_pixel", last_px, 1);

    // Ten back-to-back inputs with the consumer stalling for cycles 4..7.
    sent = 0;
    n0 = n_deliv;
    for (int k = 0; k < 40 && sent < 10; k++) begin
      rand_mat();
      thr_d = MW'($urandom_range(0, 1200));
      in_valid_d = 1'b1;
      out_ready_d = !(k >= 4 && k <= 7);
      cycle();
      if (k >= 4 && k <= 7) chk("stall_ready", last_rdy, 0);
      if (last_acc) sent++;
    end
    chk("b2b_sent", sent, 10);
    drain();
    chk("b2b_delivered", n_deliv - n0, 10);

    // Random traffic on both handshakes.
    for (int k = 0; k < 300; k++) begin
      rand_mat();
      thr_d = MW'($urandom_range(0, 1500));
      in_valid_d = ($urandom_range(0, 9) < 7);
      out_ready_d = ($urandom_range(0, 9) < 7);
      cnt_clr_d = ($urandom_range(0, 49) == 0);
      cycle();
    end
    cnt_clr_d = 1'b0;
    drain();

    // Saturation of the narrow counter.
    cnt_clr_d = 1'b1;
    cycle();
    cnt_clr_d = 1'b0;
    mat_d = '0;
    mat_d[1][2] = 8'd255;
    thr_d = '0;
    out_ready_d = 1'b1;
    sent = 0;
    for (int k = 0; k < 40 && sent < 20; k++) begin
      in_valid_d = 1'b1;
      cycle();
      if (last_acc) sent++;
    end
    drain();
    chk("sat_cnt_b", ifb.edge_cnt, 15);
    chk("sat_cnt_a", ifa.edge_cnt, 20);

    // Clear coinciding with an edge transfer.
    in_valid_d = 1'b1;
    cycle();
    in_valid_d = 1'b0;
    cycle();
    cycle();
    chk("clr_setup_valid", ifa.out_valid, 1);
    cnt_clr_d = 1'b1;
    cycle();
    cnt_clr_d = 1'b0;
    chk("clr_wins_a", ifa.edge_cnt, 0);
    chk("clr_wins_b", ifb.edge_cnt, 0);

    // Reset with the pipe full.
    send_one('0);
    in_valid_d = 1'b1;
    cycle();
    drain();
    chk("pre_rst_cnt", ifa.edge_cnt, 2);
    in_valid_d = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    in_valid_d = 1'b0;
    chk("pre_rst_valid", ifa.out_valid, 1);
    chk("pre_rst_busy", ifa.busy, 1);
    do_reset();
    out_ready_d = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("no_stale_valid", ifa.out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sobel_pipe.md
SOBEL_PIPE -- requirements
Module: sobel_pipe

Interface
REQ-001 SHALL have parameter: PIX_W, default 8, bit width of one unsigned pixel.
REQ-002 SHALL have parameter: CNT_W, default 16, width of the edge-pixel counter.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports:
  clk  input  1  rising-edge clock
  n_rst  input  1  synchronous active-low reset
  in_valid  input  1  comp_matrix/threshold valid
  in_ready  output  1  block accepts input this cycle
  comp_matrix  input  [2:0][2:0][PIX_W-1:0]  3x3 window, index [row][col], unsigned
  threshold  input  PIX_W+3  edge threshold, unsigned
  out_valid  output  1  result valid
  out_ready  input  1  downstream accepts result
  output_pixel  output  1  1 = edge
  out_mag  output  PIX_W+3  gradient magnitude, unsigned
  edge_cnt  output  CNT_W  count of edge pixels delivered
  cnt_clr  input  1  synchronous clear of edge_cnt
  busy  output  1  any pipeline stage holds valid data

Function
REQ-005 SHALL compute Gx = (m[0][2]+2m[1][2]+m[2][2]) - (m[0][0]+2m[1][0]+m[2][0]), signed, PIX_W+3 bits, no overflow.
REQ-006 SHALL compute Gy = (m[2][0]+2m[2][1]+m[2][2]) - (m[0][0]+2m[0][1]+m[0][2]), signed, PIX_W+3 bits.
REQ-007 SHALL compute out_mag = |Gx| + |Gy|, unsigned PIX_W+3 bits; max 8*(2^PIX_W-1) fits, no saturation.
REQ-008 SHALL set output_pixel = 1 iff out_mag > threshold (strict); equality gives 0.
REQ-009 SHALL sample threshold with comp_matrix on acceptance and carry it through the pipeline alongside its pixel.
REQ-010 SHALL be a 3-stage pipeline: S1 registers Gx, Gy; S2 registers out_mag; S3 registers out_mag, output_pixel, out_valid.
REQ-011 SHALL accept input when in_valid && in_ready; result appears with out_valid=1 exactly 3 cycles later when not stalled.
REQ-012 SHALL sustain throughput of one pixel per cycle when out_ready stays 1.
REQ-013 SHALL use a global stall: advance = !out_valid || out_ready; in_ready = advance; all stages hold when advance = 0.
REQ-014 SHALL hold out_valid, out_mag and output_pixel stable while out_valid && !out_ready.
REQ-015 SHALL enter a bubble (stage valid = 0) when advance = 1 and no input is accepted; bubbles are not collapsed.
REQ-016 SHALL preserve input order; no drop, no duplication.
REQ-017 SHALL increment edge_cnt by 1 on each transfer (out_valid && out_ready) with output_pixel = 1.
REQ-018 SHALL saturate edge_cnt at 2^CNT_W-1, no wrap.
REQ-019 SHALL clear edge_cnt to 0 on cnt_clr; cnt_clr with a simultaneous edge transfer yields 0 (clear wins).
REQ-020 SHALL drive busy = OR of the S1, S2 and S3 valid bits.

Reset
REQ-021 SHALL on n_rst = 0 at a clock edge clear all stage valid bits, out_valid, output_pixel, out_mag, edge_cnt; busy = 0; in_ready = 1 from the first cycle after reset.
REQ-022 SHALL discard all in-flight data on reset mid-operation; no result emerges afterwards for pre-reset inputs.

Verification
REQ-023 SHALL pass: PIX_W=8, uniform matrix all 100, threshold 127 -> out_mag 0, output_pixel 0, edge_cnt unchanged.
REQ-024 SHALL pass: m[1][2]=64, others 0; threshold 127 -> out_mag 128, pixel 1; threshold 128 -> pixel 0; m[1][0]=64 instead -> out_mag 128 (negative Gx).
REQ-025 SHALL pass: column 2 and row 2 = 255, others 0 -> Gx=765, Gy=765, out_mag 1530, pixel 1, out_valid exactly 3 cycles after acceptance.
REQ-026 SHALL pass: 10 back-to-back inputs, out_ready low for cycles 4-7 -> in_ready low while stalled, outputs held stable, all 10 results delivered in order, edge_cnt equals edge count.
REQ-027 SHALL pass: CNT_W=4, 20 edge pixels -> edge_cnt saturates at 15; cnt_clr on an edge-transfer cycle -> edge_cnt 0.
REQ-028 SHALL pass: n_rst low while 3 pixels are in flight -> out_valid 0, busy 0, edge_cnt 0 next cycle; no stale output afterwards.
